// File: rtl/data_path.sv
// -----------------------------------------------------------------------------
// data_path : 32-bit single-bus CPU datapath
//
// Purpose
//   Sixteen general registers plus HI, LO, PC, MDR, InPort and Y share one
//   combinational bus. ZHigh/ZLow capture the 64-bit result of a
//   combinational ALU whose A operand is Y and whose B operand is the bus.
//   Clock is the single clock. clear is a synchronous, active-high reset.
//
// Ports
//   Clock, clear             : clock / synchronous reset
//   Read                     : MDR source select (1 = Mdatain, 0 = bus)
//   op[4:0]                  : ALU operation
//   Mdatain[31:0]            : memory data into MDR
//   R0out..Yout              : bus source selects (R0 has the highest priority)
//   R0in..Yin                : register load enables (InPC loads PC)
//   BusOut                   : current bus value
//   mdrData                  : MDR contents
//   BusMuxInR0/R1/R2/YOut/HI/LO : register contents for observation
//
// Configuration
//   DATA_PATH_MULDIV_EN : when defined, MUL (01001) and DIV (01010) are built.
//                         When undefined, both codes give a zero result and no
//                         multiplier or divider exists.
// -----------------------------------------------------------------------------
module data_path (
   input  logic        Clock,
   input  logic        clear,
   input  logic        Read,
   input  logic [4:0]  op,
   input  logic [31:0] Mdatain,
   input  logic        R0out,
   input  logic        R1out,
   input  logic        R2out,
   input  logic        R3out,
   input  logic        R4out,
   input  logic        R5out,
   input  logic        R6out,
   input  logic        R7out,
   input  logic        R8out,
   input  logic        R9out,
   input  logic        R10out,
   input  logic        R11out,
   input  logic        R12out,
   input  logic        R13out,
   input  logic        R14out,
   input  logic        R15out,
   input  logic        HIOut,
   input  logic        LOout,
   input  logic        Zhighout,
   input  logic        Zlowout,
   input  logic        PCout,
   input  logic        MDRout,
   input  logic        InPortout,
   input  logic        Yout,
   input  logic        R0in,
   input  logic        R1in,
   input  logic        R2in,
   input  logic        R3in,
   input  logic        R4in,
   input  logic        R5in,
   input  logic        R6in,
   input  logic        R7in,
   input  logic        R8in,
   input  logic        R9in,
   input  logic        R10in,
   input  logic        R11in,
   input  logic        R12in,
   input  logic        R13in,
   input  logic        R14in,
   input  logic        R15in,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        ZHighin,
   input  logic        Zlowin,
   input  logic        InPC,
   input  logic        MDRin,
   input  logic        InPortin,
   input  logic        Yin,
   output logic [31:0] BusOut,
   output logic [31:0] mdrData,
   output logic [31:0] BusMuxInR0,
   output logic [31:0] BusMuxInR1,
   output logic [31:0] BusMuxInR2,
   output logic [31:0] BusMuxInYOut,
   output logic [31:0] BusMuxInHI,
   output logic [31:0] BusMuxInLO
);

   logic [15:0] w_rout;
   logic [15:0] w_rin;
   logic [31:0] w_bus;
   logic [31:0] w_alu_hi;
   logic [31:0] w_alu_lo;

   logic [31:0] r_gpr [16];
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_pc;
   logic [31:0] r_mdr;
   logic [31:0] r_inport;
   logic [31:0] r_y;
   logic [31:0] r_zhigh;
   logic [31:0] r_zlow;

   assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
   assign w_rin  = {R15in,  R14in,  R13in,  R12in,  R11in,  R10in,  R9in,  R8in,
                    R7in,   R6in,   R5in,   R4in,   R3in,   R2in,   R1in,  R0in};

   // Bus mux: sources are applied lowest priority first so that the
   // highest-priority active select is the last assignment and wins.
   always_comb begin
      w_bus = '0;
      if (Yout)      w_bus = r_y;
      if (InPortout) w_bus = r_inport;
      if (MDRout)    w_bus = r_mdr;
      if (PCout)     w_bus = r_pc;
      if (Zlowout)   w_bus = r_zlow;
      if (Zhighout)  w_bus = r_zhigh;
      if (LOout)     w_bus = r_lo;
      if (HIOut)     w_bus = r_hi;
      for (int i = 15; i >= 0; i--) begin
         if (w_rout[i]) w_bus = r_gpr[i];
      end
   end

   // ---------------------------------------------------------------- ALU
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [4:0]  w_sh;
   logic [31:0] w_rol;
   logic [31:0] w_ror;

   assign w_a  = r_y;
   assign w_b  = w_bus;
   assign w_sh = w_bus[4:0];

   // Rotates are built from two shifts; the zero-amount case is bypassed
   // because the complementary shift would be by the full width.
   assign w_rol = (w_sh == 5'd0) ? w_a
                : ((w_a << w_sh) | (w_a >> (6'd32 - {1'b0, w_sh})));
   assign w_ror = (w_sh == 5'd0) ? w_a
                : ((w_a >> w_sh) | (w_a << (6'd32 - {1'b0, w_sh})));

`ifdef DATA_PATH_MULDIV_EN
   logic signed [63:0] w_prod;
   logic signed [31:0] w_quot;
   logic signed [31:0] w_rem;

   assign w_prod = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});

   // Division by zero and the single overflowing case (-2^31 / -1) are
   // resolved explicitly so the result never depends on the tool.
   always_comb begin
      w_quot = '0;
      w_rem  = '0;
      if (w_b == 32'd0) begin
         w_quot = 32'hFFFF_FFFF;
         w_rem  = w_a;
      end else if ((w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF)) begin
         w_quot = 32'h8000_0000;
         w_rem  = 32'd0;
      end else begin
         w_quot = $signed(w_a) / $signed(w_b);
         w_rem  = $signed(w_a) % $signed(w_b);
      end
   end
`endif

   always_comb begin
      w_alu_hi = '0;
      w_alu_lo = '0;
      case (op)
         5'b00000: w_alu_lo = w_a + w_b;
         5'b00001: w_alu_lo = w_a - w_b;
         5'b00010: w_alu_lo = w_a & w_b;
         5'b00011: w_alu_lo = w_a | w_b;
         5'b00100: w_alu_lo = w_a >> w_sh;
         5'b00101: w_alu_lo = w_a << w_sh;
         5'b00110: w_alu_lo = w_rol;
         5'b00111: w_alu_lo = w_ror;
         5'b01000: w_alu_lo = $unsigned($signed(w_a) >>> w_sh);
`ifdef DATA_PATH_MULDIV_EN
         5'b01001: begin
            w_alu_hi = w_prod[63:32];
            w_alu_lo = w_prod[31:0];
         end
         5'b01010: begin
            w_alu_hi = w_rem;
            w_alu_lo = w_quot;
         end
`endif
         5'b01011: w_alu_lo = 32'd0 - w_b;
         5'b01100: w_alu_lo = ~w_b;
         default: begin
            w_alu_hi = '0;
            w_alu_lo = '0;
         end
      endcase
   end

   // ---------------------------------------------------------- registers
   always_ff @(posedge Clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (w_rin[i]) r_gpr[i] <= w_bus;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (clear) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_pc     <= '0;
         r_mdr    <= '0;
         r_inport <= '0;
         r_y      <= '0;
         r_zhigh  <= '0;
         r_zlow   <= '0;
      end else begin
         if (HIin)     r_hi     <= w_bus;
         if (LOin)     r_lo     <= w_bus;
         if (InPC)     r_pc     <= w_bus;
         if (InPortin) r_inport <= w_bus;
         if (Yin)      r_y      <= w_bus;
         if (MDRin)    r_mdr    <= Read ? Mdatain : w_bus;
         if (ZHighin)  r_zhigh  <= w_alu_hi;
         if (Zlowin)   r_zlow   <= w_alu_lo;
      end
   end

   assign BusOut       = w_bus;
   assign mdrData      = r_mdr;
   assign BusMuxInR0   = r_gpr[0];
   assign BusMuxInR1   = r_gpr[1];
   assign BusMuxInR2   = r_gpr[2];
   assign BusMuxInYOut = r_y;
   assign BusMuxInHI   = r_hi;
   assign BusMuxInLO   = r_lo;

endmodule

// File: tb/tb_data_path.sv
// -----------------------------------------------------------------------------
// tb_data_path : self-checking bench for data_path.
// Register state is modelled as an array indexed like the select vectors
// (0..15 = R0..R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR,
// 22 InPort, 23 Y). The ALU reference works bit-by-bit / in 64-bit integers.
// -----------------------------------------------------------------------------
module tb_data_path;

   logic        Clock;
   logic        clear;
   logic        Read;
   logic [4:0]  op;
   logic [31:0] Mdatain;
   logic [23:0] outs;
   logic [23:0] ins;
   logic [31:0] BusOut, mdrData;
   logic [31:0] BusMuxInR0, BusMuxInR1, BusMuxInR2;
   logic [31:0] BusMuxInYOut, BusMuxInHI, BusMuxInLO;

   logic [31:0] st [24];
   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;

   data_path dut (
      .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
      .R0out(outs[0]), .R1out(outs[1]), .R2out(outs[2]), .R3out(outs[3]),
      .R4out(outs[4]), .R5out(outs[5]), .R6out(outs[6]), .R7out(outs[7]),
      .R8out(outs[8]), .R9out(outs[9]), .R10out(outs[10]), .R11out(outs[11]),
      .R12out(outs[12]), .R13out(outs[13]), .R14out(outs[14]), .R15out(outs[15]),
      .HIOut(outs[16]), .LOout(outs[17]), .Zhighout(outs[18]), .Zlowout(outs[19]),
      .PCout(outs[20]), .MDRout(outs[21]), .InPortout(outs[22]), .Yout(outs[23]),
      .R0in(ins[0]), .R1in(ins[1]), .R2in(ins[2]), .R3in(ins[3]),
      .R4in(ins[4]), .R5in(ins[5]), .R6in(ins[6]), .R7in(ins[7]),
      .R8in(ins[8]), .R9in(ins[9]), .R10in(ins[10]), .R11in(ins[11]),
      .R12in(ins[12]), .R13in(ins[13]), .R14in(ins[14]), .R15in(ins[15]),
      .HIin(ins[16]), .LOin(ins[17]), .ZHighin(ins[18]), .Zlowin(ins[19]),
      .InPC(ins[20]), .MDRin(ins[21]), .InPortin(ins[22]), .Yin(ins[23]),
      .BusOut(BusOut), .mdrData(mdrData),
      .BusMuxInR0(BusMuxInR0), .BusMuxInR1(BusMuxInR1), .BusMuxInR2(BusMuxInR2),
      .BusMuxInYOut(BusMuxInYOut), .BusMuxInHI(BusMuxInHI), .BusMuxInLO(BusMuxInLO)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // First active select in list order wins; nothing selected gives 0.
   function automatic logic [31:0] bus_ref();
      for (int i = 0; i < 24; i++) begin
         if (outs[i]) return st[i];
      end
      return 32'd0;
   endfunction

   function automatic logic [63:0] alu_ref(input logic [4:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      logic [31:0] t;
      longint      p, q, r;
      logic [63:0] pv, qv, rv;
      sh = b[4:0];
      t  = a;
      case (f)
         5'd0:  return {32'd0, 32'(a + b)};
         5'd1:  return {32'd0, 32'(a - b)};
         5'd2:  return {32'd0, a & b};
         5'd3:  return {32'd0, a | b};
         5'd4:  begin repeat (sh) t = {1'b0, t[31:1]};  return {32'd0, t}; end
         5'd5:  begin repeat (sh) t = {t[30:0], 1'b0};  return {32'd0, t}; end
         5'd6:  begin repeat (sh) t = {t[30:0], t[31]}; return {32'd0, t}; end
         5'd7:  begin repeat (sh) t = {t[0], t[31:1]};  return {32'd0, t}; end
         5'd8:  begin repeat (sh) t = {t[31], t[31:1]}; return {32'd0, t}; end
`ifdef DATA_PATH_MULDIV_EN
         5'd9:  begin
            p  = longint'($signed(a)) * longint'($signed(b));
            pv = p;
            return pv;
         end
         5'd10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q  = longint'($signed(a)) / longint'($signed(b));
            r  = longint'($signed(a)) % longint'($signed(b));
            qv = q;
            rv = r;
            return {rv[31:0], qv[31:0]};
         end
`endif
         5'd11: return {32'd0, 32'(32'd0 - b)};
         5'd12: return {32'd0, ~b};
         default: return 64'd0;
      endcase
   endfunction

   task automatic idle();
      clear = 1'b0; Read = 1'b0; op = 5'd0; Mdatain = 32'd0;
      outs = '0; ins = '0;
   endtask

   // One clock with the currently driven inputs: checks the bus, advances the
   // model on the edge, then checks every observable register.
   task automatic cycle(input string tag);
      logic [31:0] eb;
      logic [63:0] z;
      #1;
      eb = bus_ref();
      check_val({tag, ":bus"}, BusOut, eb);
      z = alu_ref(op, st[23], eb);
      @(posedge Clock);
      for (int i = 0; i < 24; i++) begin
         if (clear)            st[i] = 32'd0;
         else if (ins[i]) begin
            if (i == 18)      st[i] = z[63:32];
            else if (i == 19) st[i] = z[31:0];
            else if (i == 21) st[i] = Read ? Mdatain : eb;
            else              st[i] = eb;
         end
      end
      @(negedge Clock);
      check_val({tag, ":mdr"}, mdrData,      st[21]);
      check_val({tag, ":r0"},  BusMuxInR0,   st[0]);
      check_val({tag, ":r1"},  BusMuxInR1,   st[1]);
      check_val({tag, ":r2"},  BusMuxInR2,   st[2]);
      check_val({tag, ":y"},   BusMuxInYOut, st[23]);
      check_val({tag, ":hi"},  BusMuxInHI,   st[16]);
      check_val({tag, ":lo"},  BusMuxInLO,   st[17]);
      n_txn++;
      $display("txn %0d %s clr=%0b op=%0d outs=%h ins=%h bus=%h", n_txn, tag,
               clear, op, outs, ins, eb);
   endtask

   task automatic load_reg(input int idx, input logic [31:0] v);
      idle(); Mdatain = v; Read = 1'b1; ins[21] = 1'b1;
      cycle("ld_mdr");
      idle(); outs[21] = 1'b1; ins[idx] = 1'b1;
      cycle("ld_xfer");
   endtask

   // ALU op with Y preloaded and B taken from R2, result into both Z halves;
   // then each Z half is read back over the bus against a fixed value.
   task automatic alu_case(input string tag, input logic [4:0] f, input logic [31:0] y,
                           input logic [31:0] b, input bit b_zero,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      load_reg(23, y);
      load_reg(2, b);
      idle(); op = f; outs[2] = ~b_zero; ins[18] = 1'b1; ins[19] = 1'b1;
      cycle({tag, ":op"});
      idle(); outs[18] = 1'b1; #1;
      check_val({tag, ":zhigh"}, BusOut, exp_hi);
      cycle({tag, ":rdh"});
      idle(); outs[19] = 1'b1; #1;
      check_val({tag, ":zlow"}, BusOut, exp_lo);
      cycle({tag, ":rdl"});
   endtask

   initial begin
      for (int i = 0; i < 24; i++) st[i] = 32'd0;
      idle();
      clear = 1'b1;
      cycle("reset");
      check_val("reset:r0", BusMuxInR0, 32'd0);
      check_val("reset:y",  BusMuxInYOut, 32'd0);

      // MDR load then transfer to Y
      load_reg(23, 32'hFFFF_FFF4);
      check_val("mdr_y:mdr", mdrData, 32'hFFFF_FFF4);
      check_val("mdr_y:y",   BusMuxInYOut, 32'hFFFF_FFF4);

      // ROL, then Z halves moved to R1 / R0
      load_reg(2, 32'd5);
      idle(); op = 5'b00110; outs[2] = 1'b1; ins[18] = 1'b1; ins[19] = 1'b1;
      cycle("rol:op");
      idle(); outs[19] = 1'b1; ins[1] = 1'b1; cycle("rol:zl_r1");
      idle(); outs[18] = 1'b1; ins[0] = 1'b1; cycle("rol:zh_r0");
      check_val("rol:r1", BusMuxInR1, 32'hFFFF_FE9F);
      check_val("rol:r0", BusMuxInR0, 32'd0);

      // shift by zero passes A unchanged
      alu_case("shl0", 5'b00101, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0, 32'd0, 32'h1234_5678);
`ifdef DATA_PATH_MULDIV_EN
      alu_case("mul",  5'b01001, 32'hFFFF_FFFD, 32'd7,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      alu_case("div",  5'b01010, 32'd17,        32'd5,  1'b0, 32'd2,  32'd3);
      alu_case("div0", 5'b01010, 32'd17,        32'd0,  1'b1, 32'd17, 32'hFFFF_FFFF);
`else
      alu_case("mul",  5'b01001, 32'hFFFF_FFFD, 32'd7,  1'b0, 32'd0, 32'd0);
      alu_case("div",  5'b01010, 32'd17,        32'd5,  1'b0, 32'd0, 32'd0);
      alu_case("div0", 5'b01010, 32'd17,        32'd0,  1'b1, 32'd0, 32'd0);
`endif

      // bus priority and idle bus
      load_reg(1, 32'hAAAA_0001);
      load_reg(5, 32'h5555_0005);
      idle(); outs[1] = 1'b1; outs[5] = 1'b1; #1;
      check_val("prio:bus", BusOut, 32'hAAAA_0001);
      cycle("prio");
      idle(); #1;
      check_val("idle:bus", BusOut, 32'd0);
      cycle("idle");

      // clear overrides a pending load
      load_reg(4, 32'h0000_1234);
      idle(); clear = 1'b1; outs[4] = 1'b1; ins[3] = 1'b1; #1;
      check_val("clr:bus", BusOut, 32'h0000_1234);
      cycle("clr");
      check_val("clr:r0", BusMuxInR0, 32'd0);
      check_val("clr:hi", BusMuxInHI, 32'd0);
      idle(); outs[3] = 1'b1; #1;
      check_val("clr:r3", BusOut, 32'd0);
      cycle("clr_rd");

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         idle();
         for (int i = 0; i < 24; i++) begin
            outs[i] = ($urandom_range(0, 11) == 0);
            ins[i]  = ($urandom_range(0, 3) == 0);
         end
         clear   = ($urandom_range(0, 39) == 0);
         Read    = $urandom_range(0, 1) == 1;
         op      = 5'($urandom_range(0, 15));
         Mdatain = $urandom;
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Read, input, 1 bit: MDR input select (1 = Mdatain, 0 = bus).
REQ-004 SHALL have port op, input, 5 bits: ALU operation select.
REQ-005 SHALL have port Mdatain, input, 32 bits: memory data into MDR.
REQ-006 SHALL have ports R0out..R15out, HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, input, 1 bit each: bus source selects.
REQ-007 SHALL have ports R0in..R15in, HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin, input, 1 bit each: register load enables (InPC = PC load).
REQ-008 SHALL have port BusOut, output, 32 bits: current bus value.
REQ-009 SHALL have port mdrData, output, 32 bits: MDR contents.
REQ-010 SHALL have ports BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInYOut, BusMuxInHI, BusMuxInLO, output, 32 bits each: contents of R0, R1, R2, Y, HI, LO.
REQ-011 SHALL use ports in the order: Clock, clear, Read, op, Mdatain, out-selects (REQ-006 order), in-enables (REQ-007 order), then REQ-008..REQ-010 outputs.

Function
REQ-012 SHALL contain 32-bit registers R0-R15, HI, LO, PC, MDR, InPort, Y, ZHigh, ZLow.
REQ-013 Bus SHALL be combinational: the selected source, or 0 when none is selected; multiple selects resolve by fixed priority R0..R15, HI, LO, ZHigh, ZLow, PC, MDR, InPort, Y (first wins).
REQ-014 Each register except MDR/ZHigh/ZLow SHALL load the bus on a rising edge while its enable is 1, otherwise hold.
REQ-015 MDR SHALL load Mdatain when MDRin=1 and Read=1, load the bus when MDRin=1 and Read=0.
REQ-016 ALU SHALL be combinational with A = Y and B = bus, producing 64-bit result {hi,lo}; ZHighin loads hi into ZHigh, Zlowin loads lo into ZLow, independently and in the same cycle if both are set.
REQ-017 op encoding (lo result; hi = 0 unless stated): 00000 ADD A+B; 00001 SUB A-B; 00010 AND; 00011 OR; 00100 SHR logical A>>B[4:0]; 00101 SHL A<<B[4:0]; 00110 ROL A rotated left by B[4:0]; 00111 ROR; 01000 SHRA arithmetic; 01001 MUL signed, hi:lo = 64-bit product; 01010 DIV signed, lo = quotient, hi = remainder (sign of A); 01011 NEG = -B; 01100 NOT = ~B; all other codes give 0.
REQ-018 Arithmetic SHALL wrap modulo 2^32 with no flags; shift amount 0 SHALL pass A unchanged.
REQ-019 DIV by zero SHALL give lo = 32'hFFFFFFFF, hi = A.
REQ-020 Register-to-register transfer through the bus SHALL take one clock; an ALU operation SHALL take one clock (result visible in Z after the edge).

Reset
REQ-021 clear=1 at a rising edge SHALL zero every register, overriding all load enables; outputs SHALL read 0 afterwards. Bus and ALU remain combinational during clear.

Configuration
REQ-022 Macro DATA_PATH_MULDIV_EN: defined -> MUL and DIV per REQ-017; undefined -> op 01001 and 01010 give hi = lo = 0 and no multiplier/divider logic is built.

Verification
REQ-023 MDR load then transfer: Mdatain=0xFFFFFFF4, Read=1, MDRin=1; then MDRout, Yin -> mdrData and BusMuxInYOut = 0xFFFFFFF4.
REQ-024 ROL: Y=0xFFFFFFF4, R2=5, op=00110, R2out, ZHighin, Zlowin; then Zlowout→R1, Zhighout→R0 -> R1=0xFFFFFE9F, R0=0.
REQ-025 MUL (macro defined): Y=-3, bus=7, op=01001 -> ZHigh=0xFFFFFFFF, ZLow=0xFFFFFFEB; macro undefined -> both 0.
REQ-026 DIV: Y=17, bus=5 -> ZLow=3, ZHigh=2; bus=0 -> ZLow=0xFFFFFFFF, ZHigh=17.
REQ-027 Bus priority and idle: R1out and R5out both 1 -> BusOut = R1; no select -> BusOut=0.
REQ-028 clear asserted with R3in=1 and bus=0x1234 -> R3=0 after edge; all BusMuxIn* outputs = 0.
